// File: rtl/regfile_sb.sv
// regfile_sb -- integer register file with a pending-write scoreboard.
//
// Receives writebacks from the WB stage, serves two combinational read ports
// (with same-cycle writeback bypass) to decode, and counts in-flight
// destination writes per register so decode can be held on a RAW hazard.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data    writeback strobe, 6-bit destination, data
//   rd_addr1/rd_addr2        read addresses (rs1, rs2)
//   rd_data1/rd_data2        combinational read data
//   rs1_used/rs2_used        decoded instruction consumes rs1 / rs2
//   issue_en/issue_addr      instruction leaves ID and will write issue_addr
//   sb_clear                 flush: drop all pending-write counts
//   stall                    RAW hazard, hold ID
//   sb_overflow              sticky: issue to a saturated counter
//   sb_underflow             sticky: writeback to a register with no pending write
//
// Addresses with bit 5 set are non-register destinations: never written,
// read as zero, never tracked. x0 behaves the same way.
module regfile_sb #(
  parameter int N    = 32,
  parameter int NREG = 32,
  parameter int CW   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [5:0]   wr_addr,
  input  logic [N-1:0] wr_data,
  input  logic [5:0]   rd_addr1,
  input  logic [5:0]   rd_addr2,
  output logic [N-1:0] rd_data1,
  output logic [N-1:0] rd_data2,
  input  logic         rs1_used,
  input  logic         rs2_used,
  input  logic         issue_en,
  input  logic [5:0]   issue_addr,
  input  logic         sb_clear,
  output logic         stall,
  output logic         sb_overflow,
  output logic         sb_underflow
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [N-1:0]  regs [NREG];
  logic [CW-1:0] cnt  [NREG];

  logic          wr_ok, issue_ok, rd1_ok, rd2_ok;
  logic [4:0]    wr_idx, issue_idx, rd1_idx, rd2_idx;
  logic          dec_hit1, dec_hit2, hz1, hz2;
  logic [CW-1:0] rem1, rem2;
  logic [NREG-1:0] inc_vec, dec_vec;

  // True for a real, writable architectural register (not x0, not bit-5 space).
  function automatic logic tgt_ok(input logic [5:0] a);
    return !a[5] && (a[4:0] != 5'd0);
  endfunction

  assign wr_idx    = wr_addr[4:0];
  assign issue_idx = issue_addr[4:0];
  assign rd1_idx   = rd_addr1[4:0];
  assign rd2_idx   = rd_addr2[4:0];

  assign wr_ok  = wr_en && tgt_ok(wr_addr);
  assign rd1_ok = tgt_ok(rd_addr1);
  assign rd2_ok = tgt_ok(rd_addr2);

  // Read ports with writeback bypass; invalid/x0 addresses read zero.
  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if (rd1_ok) rd_data1 = (wr_ok && (wr_addr == rd_addr1)) ? wr_data : regs[rd1_idx];
    if (rd2_ok) rd_data2 = (wr_ok && (wr_addr == rd_addr2)) ? wr_data : regs[rd2_idx];
  end

  // A writeback landing this cycle retires one pending write before the
  // hazard is judged, so the last outstanding write causes no bubble.
  always_comb begin
    dec_hit1 = wr_ok && (wr_idx == rd1_idx);
    dec_hit2 = wr_ok && (wr_idx == rd2_idx);
    rem1     = cnt[rd1_idx] - CW'(dec_hit1);
    rem2     = cnt[rd2_idx] - CW'(dec_hit2);
    hz1      = rd1_ok && (rem1 != '0);
    hz2      = rd2_ok && (rem2 != '0);
    stall    = (rs1_used && hz1) || (rs2_used && hz2);
  end

  // A stalled instruction has not left ID, so its issue must not be counted.
  assign issue_ok = issue_en && !stall && tgt_ok(issue_addr);

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue_ok) inc_vec[issue_idx] = 1'b1;
    if (wr_ok)    dec_vec[wr_idx]    = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
      sb_overflow  <= 1'b0;
      sb_underflow <= 1'b0;
    end else begin
      if (wr_ok) regs[wr_idx] <= wr_data;
      if (sb_clear) begin
        for (int i = 0; i < NREG; i++) cnt[i] <= '0;
      end else begin
        for (int i = 1; i < NREG; i++) begin
          case ({inc_vec[i], dec_vec[i]})
            2'b10: begin
              if (cnt[i] == CNT_MAX) sb_overflow <= 1'b1;
              else                   cnt[i] <= cnt[i] + CW'(1);
            end
            2'b01: begin
              if (cnt[i] == '0) sb_underflow <= 1'b1;
              else              cnt[i] <= cnt[i] - CW'(1);
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic [5:0]  rd_addr1, rd_addr2;
  logic [31:0] rd_data1, rd_data2;
  logic        rs1_used, rs2_used;
  logic        issue_en;
  logic [5:0]  issue_addr;
  logic        sb_clear;
  logic        stall, sb_overflow, sb_underflow;

  int errors = 0;
  int checks = 0;

  localparam int CMOD = 4;  // counter modulus for CW=2

  // Reference model: architectural state as plain arrays.
  logic [31:0] mregs [32];
  int          mcnt  [32];
  bit          movf, munf;

  regfile_sb #(.N(32), .NREG(32), .CW(2)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rs1_used(rs1_used), .rs2_used(rs2_used),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .sb_clear(sb_clear), .stall(stall),
    .sb_overflow(sb_overflow), .sb_underflow(sb_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic bit m_ok(input logic [5:0] a);
    return (a[5] == 1'b0) && (a[4:0] != 5'd0);
  endfunction

  function automatic logic [31:0] m_rd(input logic [5:0] a);
    if (!m_ok(a)) return 32'd0;
    if (wr_en && m_ok(wr_addr) && wr_addr == a) return wr_data;
    return mregs[a[4:0]];
  endfunction

  function automatic bit m_hz(input logic [5:0] a);
    int hit;
    if (!m_ok(a)) return 1'b0;
    hit = (wr_en && m_ok(wr_addr) && wr_addr[4:0] == a[4:0]) ? 1 : 0;
    return ((mcnt[a[4:0]] - hit + CMOD) % CMOD) != 0;
  endfunction

  function automatic bit m_stall();
    return (rs1_used && m_hz(rd_addr1)) || (rs2_used && m_hz(rd_addr2));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_en = 0; wr_addr = 0; wr_data = 0;
    rd_addr1 = 0; rd_addr2 = 0; rs1_used = 0; rs2_used = 0;
    issue_en = 0; issue_addr = 0; sb_clear = 0;
  endtask

  // Advance the model by one clock edge using the current inputs, then the DUT.
  task automatic tick();
    bit ms;
    int ii, wi;
    ms = m_stall();
    if (rst) begin
      for (int r = 0; r < 32; r++) begin mregs[r] = 0; mcnt[r] = 0; end
      movf = 0; munf = 0;
    end else begin
      ii = (issue_en && !ms && m_ok(issue_addr)) ? int'(issue_addr[4:0]) : -1;
      wi = (wr_en && m_ok(wr_addr)) ? int'(wr_addr[4:0]) : -1;
      if (wi >= 0) mregs[wi] = wr_data;
      if (sb_clear) begin
        for (int r = 0; r < 32; r++) mcnt[r] = 0;
      end else if (ii != wi) begin
        if (ii >= 0) begin
          if (mcnt[ii] == CMOD - 1) movf = 1; else mcnt[ii]++;
        end
        if (wi >= 0) begin
          if (mcnt[wi] == 0) munf = 1; else mcnt[wi]--;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] a;
    for (int r = 0; r < 32; r++) begin mregs[r] = 0; mcnt[r] = 0; end
    movf = 0; munf = 0;

    // Reset and full read sweep
    idle(); rst = 1;
    tick();
    rst = 0;
    for (int k = 0; k < 32; k++) begin
      rd_addr1 = 6'(k); rd_addr2 = 6'(31 - k);
      #1;
      chk("reset_rd1", rd_data1, 32'd0);
      chk("reset_rd2", rd_data2, 32'd0);
    end
    rs1_used = 1; rs2_used = 1; #1;
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_ovf", {31'd0, sb_overflow}, 32'd0);
    chk("reset_unf", {31'd0, sb_underflow}, 32'd0);

    // Write x5 with bypass, x0 dropped, bit-5 address dropped
    idle(); issue_en = 1; issue_addr = 5; tick();
    idle(); wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; rd_addr1 = 5; #1;
    chk("bypass_x5", rd_data1, 32'hDEADBEEF);
    tick(); wr_en = 0; #1;
    chk("array_x5", rd_data1, 32'hDEADBEEF);
    wr_en = 1; wr_addr = 0; wr_data = 32'h1234; rd_addr1 = 0; #1;
    chk("x0_bypass", rd_data1, 32'd0);
    tick(); wr_en = 0; #1;
    chk("x0_array", rd_data1, 32'd0);
    wr_en = 1; wr_addr = 6'h25; wr_data = 32'hCAFE; rd_addr1 = 6'h25; rd_addr2 = 5; #1;
    chk("hi_bypass", rd_data1, 32'd0);
    tick(); wr_en = 0; #1;
    chk("hi_rd", rd_data1, 32'd0);
    chk("hi_x5_kept", rd_data2, 32'hDEADBEEF);

    // Single pending write on x7, stall held, gated re-issue, zero-bubble resolve
    idle(); issue_en = 1; issue_addr = 7; tick();
    idle(); rd_addr1 = 7; rs1_used = 1;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin issue_en = 1; issue_addr = 7; end
      #1;
      chk("x7_stall", {31'd0, stall}, 32'd1);
      tick();
      issue_en = 0;
    end
    wr_en = 1; wr_addr = 7; wr_data = 32'hA5A5A5A5; #1;
    chk("x7_resolve", {31'd0, stall}, 32'd0);
    chk("x7_bypass", rd_data1, 32'hA5A5A5A5);
    tick(); wr_en = 0; #1;
    chk("x7_after", {31'd0, stall}, 32'd0);
    chk("x7_array", rd_data1, 32'hA5A5A5A5);

    // Two pending writes on x9
    idle(); issue_en = 1; issue_addr = 9; tick(); tick();
    idle(); rd_addr2 = 9; rs2_used = 1; #1;
    chk("x9_cnt2", {31'd0, stall}, 32'd1);
    wr_en = 1; wr_addr = 9; wr_data = 32'h99; #1;
    chk("x9_wb1", {31'd0, stall}, 32'd1);
    tick(); wr_en = 0; #1;
    chk("x9_cnt1", {31'd0, stall}, 32'd1);
    rs2_used = 0; issue_en = 1; issue_addr = 9; wr_en = 1; wr_addr = 9; wr_data = 32'h9A;
    tick();
    idle(); rd_addr2 = 9; rs2_used = 1; #1;
    chk("x9_inc_dec", {31'd0, stall}, 32'd1);
    wr_en = 1; wr_addr = 9; wr_data = 32'h9B; #1;
    chk("x9_wb2", {31'd0, stall}, 32'd0);
    chk("x9_bypass2", rd_data2, 32'h9B);
    tick(); wr_en = 0; #1;
    chk("x9_clear", {31'd0, stall}, 32'd0);

    // Saturation on x3, underflow on x4, sb_clear
    idle(); issue_en = 1; issue_addr = 3;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("x3_ovf", {31'd0, sb_overflow}, (k == 3) ? 32'd1 : 32'd0);
    end
    idle(); rd_addr1 = 3; rs1_used = 1; #1;
    chk("x3_stall", {31'd0, stall}, 32'd1);
    idle(); wr_en = 1; wr_addr = 4; wr_data = 32'h44; tick();
    idle(); rd_addr2 = 4; rs2_used = 1; #1;
    chk("x4_unf", {31'd0, sb_underflow}, 32'd1);
    chk("x4_nostall", {31'd0, stall}, 32'd0);
    chk("ovf_sticky", {31'd0, sb_overflow}, 32'd1);
    idle(); wr_en = 1; wr_addr = 3; wr_data = 32'h33; tick(); tick();
    idle(); rd_addr1 = 3; rs1_used = 1; #1;
    chk("x3_sat_cnt", {31'd0, stall}, 32'd1);
    sb_clear = 1; tick();
    idle(); rd_addr1 = 3; rs1_used = 1; #1;
    chk("clr_stall", {31'd0, stall}, 32'd0);
    chk("clr_ovf", {31'd0, sb_overflow}, 32'd1);
    chk("clr_unf", {31'd0, sb_underflow}, 32'd1);

    // Mid-operation reset
    idle(); issue_en = 1; issue_addr = 10; tick();
    wr_en = 1; wr_addr = 10; wr_data = 32'h55; tick();
    idle(); issue_en = 1; issue_addr = 10; tick();
    idle(); rd_addr1 = 10; #1;
    chk("x10_data", rd_data1, 32'h55);
    rs1_used = 1; #1;
    chk("x10_stall", {31'd0, stall}, 32'd1);
    rst = 1; wr_en = 1; wr_addr = 10; wr_data = 32'h77; issue_en = 1; issue_addr = 11;
    tick(); rst = 0;
    idle(); rd_addr1 = 10; rs1_used = 1; rd_addr2 = 11; rs2_used = 1; #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_x10", rd_data1, 32'd0);
    chk("rst_ovf", {31'd0, sb_overflow}, 32'd0);
    chk("rst_unf", {31'd0, sb_underflow}, 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 99) == 0);
      sb_clear = ($urandom_range(0, 31) == 0);
      wr_en    = $urandom_range(0, 1);
      a = 6'($urandom_range(0, 11)); if ($urandom_range(0, 9) == 0) a[5] = 1'b1; wr_addr = a;
      wr_data  = $urandom;
      a = 6'($urandom_range(0, 11)); if ($urandom_range(0, 9) == 0) a[5] = 1'b1; rd_addr1 = a;
      a = 6'($urandom_range(0, 11)); if ($urandom_range(0, 9) == 0) a[5] = 1'b1; rd_addr2 = a;
      rs1_used = $urandom_range(0, 1);
      rs2_used = $urandom_range(0, 1);
      issue_en = $urandom_range(0, 1);
      a = 6'($urandom_range(0, 11)); if ($urandom_range(0, 9) == 0) a[5] = 1'b1; issue_addr = a;
      #1;
      chk("rnd_rd1", rd_data1, m_rd(rd_addr1));
      chk("rnd_rd2", rd_data2, m_rd(rd_addr2));
      chk("rnd_stall", {31'd0, stall}, {31'd0, m_stall()});
      chk("rnd_ovf", {31'd0, sb_overflow}, {31'd0, movf});
      chk("rnd_unf", {31'd0, sb_underflow}, {31'd0, munf});
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
